// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort hunt, zero destuffing, LSB-first byte assembly.
// Flag/abort strobes trail the final pattern bit by two edges; the line has no backpressure.
module hdlc_rx_deframer #(
  parameter int MAX_BYTES = 128,
  parameter int SIZE_W    = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx,
  input  logic              RxEN,
  output logic              Rx_FlagDetect,
  output logic              Rx_AbortDetect,
  output logic              Rx_ValidFrame,
  output logic              Rx_AbortSignal,
  output logic [7:0]        Rx_Data,
  output logic              Rx_WrBuff,
  output logic              Rx_EoF,
  output logic              Rx_FrameError,
  output logic              Rx_Overflow,
  output logic [SIZE_W-1:0] Rx_FrameSize
);

  typedef enum logic [1:0] {HUNT, FLAG_SEEN, IN_FRAME} state_t;

  localparam logic [SIZE_W-1:0] MAX_CNT = SIZE_W'(MAX_BYTES);

  state_t            state, stateNext;
  logic [7:0]        win;
  logic [6:0]        shiftReg;
  logic              wasEn;
  logic [3:0]        skipCnt;
  logic [2:0]        onesCnt;
  logic [2:0]        bitCnt;
  logic [SIZE_W-1:0] byteCnt;

  logic candBit, isFlag, isAbort, skipping, destuff, accept;
  logic closeEv, abortEv, byteDone, haveRoom;

  assign Rx_ValidFrame = (state == IN_FRAME);

  always_comb begin
    candBit  = win[7];
    // A window left over from before a disable must not match.
    isFlag   = wasEn && (win == 8'h7E);
    isAbort  = wasEn && (win == 8'h7F);
    skipping = isFlag || isAbort || (skipCnt != 4'd0);
    destuff  = !skipping && (onesCnt == 3'd5) && !candBit;
    accept   = RxEN && !skipping && !destuff && (state != HUNT);
    closeEv  = RxEN && Rx_FlagDetect && (state == IN_FRAME);
    abortEv  = RxEN && Rx_AbortDetect && (state == IN_FRAME);
    byteDone = accept && (state == IN_FRAME) && (bitCnt == 3'd7) && !closeEv && !abortEv;
    haveRoom = (byteCnt < MAX_CNT);

    stateNext = state;
    if (!RxEN) begin
      stateNext = HUNT;
    end else begin
      case (state)
        HUNT:      if (Rx_FlagDetect) stateNext = FLAG_SEEN;
        FLAG_SEEN: if (Rx_AbortDetect) stateNext = HUNT;
                   else if (!Rx_FlagDetect && accept) stateNext = IN_FRAME;
        IN_FRAME:  if (Rx_AbortDetect) stateNext = HUNT;
                   else if (Rx_FlagDetect) stateNext = FLAG_SEEN;
        default:   stateNext = HUNT;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= HUNT;
    else     state <= stateNext;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      win            <= 8'hFF;
      shiftReg       <= '0;
      wasEn          <= 1'b0;
      skipCnt        <= '0;
      onesCnt        <= '0;
      bitCnt         <= '0;
      byteCnt        <= '0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_Data        <= '0;
      Rx_WrBuff      <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_FrameSize   <= '0;
    end else if (!RxEN) begin
      wasEn          <= 1'b0;
      skipCnt        <= '0;
      onesCnt        <= '0;
      bitCnt         <= '0;
      byteCnt        <= '0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_WrBuff      <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_Overflow    <= 1'b0;
    end else begin
      wasEn          <= 1'b1;
      // First enabled edge restarts from an all-ones window.
      win            <= wasEn ? {win[6:0], Rx} : {7'h7F, Rx};
      Rx_FlagDetect  <= isFlag;
      Rx_AbortDetect <= isAbort;
      Rx_AbortSignal <= abortEv;
      Rx_EoF         <= closeEv;
      Rx_WrBuff      <= byteDone && haveRoom;

      // The flag bits still in the window drain out over the next eight edges.
      if (isFlag)                skipCnt <= 4'd7;
      else if (skipCnt != 4'd0)  skipCnt <= skipCnt - 4'd1;

      if (skipping || !candBit)  onesCnt <= '0;
      else if (onesCnt != 3'd7)  onesCnt <= onesCnt + 3'd1;

      if (accept) shiftReg <= {candBit, shiftReg[6:1]};

      if (closeEv || abortEv || state == HUNT) begin
        bitCnt  <= '0;
        byteCnt <= '0;
      end else begin
        if (accept)                bitCnt  <= bitCnt + 3'd1;
        if (byteDone && haveRoom)  byteCnt <= byteCnt + 1'b1;
      end

      if (byteDone && haveRoom) Rx_Data <= {candBit, shiftReg};

      if (state == FLAG_SEEN && stateNext == IN_FRAME) Rx_Overflow <= 1'b0;
      else if (byteDone && !haveRoom)                  Rx_Overflow <= 1'b1;

      if (closeEv) begin
        Rx_FrameSize  <= byteCnt;
        Rx_FrameError <= (bitCnt != 3'd0);
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: a bit-level transmitter model drives two instances
// (128-byte and 4-byte limits) and frame-level expectations are checked against logged strobes.
module tb_hdlc_rx_deframer;

  logic Clk = 1'b0;
  logic Rst, Rx, RxEN;

  logic fdA, adA, vfA, asA, wbA, eofA, feA, ovA;
  logic [7:0] dA, fsA;
  logic fdB, adB, vfB, asB, wbB, eofB, feB, ovB;
  logic [7:0] dB, fsB;

  hdlc_rx_deframer #(.MAX_BYTES(128), .SIZE_W(8)) dutA (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN),
    .Rx_FlagDetect(fdA), .Rx_AbortDetect(adA), .Rx_ValidFrame(vfA), .Rx_AbortSignal(asA),
    .Rx_Data(dA), .Rx_WrBuff(wbA), .Rx_EoF(eofA), .Rx_FrameError(feA),
    .Rx_Overflow(ovA), .Rx_FrameSize(fsA));

  hdlc_rx_deframer #(.MAX_BYTES(4), .SIZE_W(8)) dutB (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN),
    .Rx_FlagDetect(fdB), .Rx_AbortDetect(adB), .Rx_ValidFrame(vfB), .Rx_AbortSignal(asB),
    .Rx_Data(dB), .Rx_WrBuff(wbB), .Rx_EoF(eofB), .Rx_FrameError(feB),
    .Rx_Overflow(ovB), .Rx_FrameSize(fsB));

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] size;
    logic       err;
    logic       ovf;
  } eof_t;

  int   total = 0;
  int   bad   = 0;
  int   edgeCnt = 0;
  logic [7:0] wrQA[$], wrQB[$];
  eof_t eofQA[$], eofQB[$];
  int   flagQ[$], abDetQ[$], abSigQ[$];
  logic abSigVf;
  logic [7:0] txBytes[$];

  always @(posedge Clk) edgeCnt++;

  // Event log; each entry is tagged with the edge that samples the strobe.
  always @(negedge Clk) begin
    if (Rst === 1'b0) begin
      if (wbA)  wrQA.push_back(dA);
      if (wbB)  wrQB.push_back(dB);
      if (eofA) eofQA.push_back({fsA, feA, ovA});
      if (eofB) eofQB.push_back({fsB, feB, ovB});
      if (fdA)  flagQ.push_back(edgeCnt + 1);
      if (adA)  abDetQ.push_back(edgeCnt + 1);
      if (asA) begin
        abSigQ.push_back(edgeCnt + 1);
        abSigVf = vfA;
      end
    end
  end

  task automatic clear_log;
    wrQA.delete(); wrQB.delete(); eofQA.delete(); eofQB.delete();
    flagQ.delete(); abDetQ.delete(); abSigQ.delete();
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    @(posedge Clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  // Opening flag, txBytes then np trailing bits with zero insertion, closing flag.
  task automatic send_frame(input int np, input logic [7:0] pbits, output int tOpen, output int tClose);
    logic bits[$];
    int ones;
    foreach (txBytes[k]) for (int i = 0; i < 8; i++) bits.push_back(txBytes[k][i]);
    for (int i = 0; i < np; i++) bits.push_back(pbits[i]);
    send_raw(8'h7E);
    tOpen = edgeCnt;
    ones = 0;
    foreach (bits[i]) begin
      send_bit(bits[i]);
      if (bits[i]) ones++; else ones = 0;
      if (ones == 5) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
    send_raw(8'h7E);
    tClose = edgeCnt;
  endtask

  task automatic test_reset;
    Rst = 1'b1; RxEN = 1'b0; Rx = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if ({fdA, adA, vfA, asA, dA, wbA, eofA, feA, ovA, fsA} !== 30'd0) begin
      bad++; $display("FAIL reset_outputs_A got=%h want=0", {fdA, adA, vfA, asA, dA, wbA, eofA, feA, ovA, fsA});
    end
    total++;
    if ({fdB, adB, vfB, asB, dB, wbB, eofB, feB, ovB, fsB} !== 30'd0) begin
      bad++; $display("FAIL reset_outputs_B got=%h want=0", {fdB, adB, vfB, asB, dB, wbB, eofB, feB, ovB, fsB});
    end
    Rst = 1'b0; RxEN = 1'b1;
    clear_log();
    idle(12);
    total++;
    if (flagQ.size() + abDetQ.size() + wrQA.size() + eofQA.size() !== 0 || vfA !== 1'b0) begin
      bad++; $display("FAIL idle_no_events got=%0d vf=%b want=0 vf=0", flagQ.size() + abDetQ.size() + wrQA.size() + eofQA.size(), vfA);
    end
  endtask

  task automatic test_basic;
    int tO, tC;
    clear_log();
    txBytes = '{8'hA5, 8'h3C};
    send_frame(0, 8'h00, tO, tC);
    idle(10);
    total++;
    if (flagQ.size() !== 2) begin
      bad++; $display("FAIL basic_flag_count got=%0d want=2", flagQ.size());
    end else begin
      total++;
      if (flagQ[0] !== tO + 2) begin bad++; $display("FAIL basic_flag1_edge got=%0d want=%0d", flagQ[0], tO + 2); end
      total++;
      if (flagQ[1] !== tC + 2) begin bad++; $display("FAIL basic_flag2_edge got=%0d want=%0d", flagQ[1], tC + 2); end
    end
    total++;
    if (wrQA.size() !== 2) begin
      bad++; $display("FAIL basic_wr_count got=%0d want=2", wrQA.size());
    end else begin
      total++;
      if (wrQA[0] !== 8'hA5 || wrQA[1] !== 8'h3C) begin
        bad++; $display("FAIL basic_wr_data got=%h,%h want=a5,3c", wrQA[0], wrQA[1]);
      end
    end
    total++;
    if (eofQA.size() !== 1) begin
      bad++; $display("FAIL basic_eof_count got=%0d want=1", eofQA.size());
    end else begin
      total++;
      if (eofQA[0] !== eof_t'({8'd2, 1'b0, 1'b0})) begin
        bad++; $display("FAIL basic_eof got=%h want=%h", eofQA[0], eof_t'({8'd2, 1'b0, 1'b0}));
      end
    end
    total++;
    if (abSigQ.size() !== 0) begin bad++; $display("FAIL basic_no_abortsig got=%0d want=0", abSigQ.size()); end
  endtask

  task automatic test_stuffed;
    int tO, tC;
    clear_log();
    txBytes = '{8'hFF};
    send_frame(0, 8'h00, tO, tC);
    idle(10);
    total++;
    if (wrQA.size() !== 1 || eofQA.size() !== 1) begin
      bad++; $display("FAIL stuffed_counts got wr=%0d eof=%0d want wr=1 eof=1", wrQA.size(), eofQA.size());
    end else begin
      total++;
      if (wrQA[0] !== 8'hFF) begin bad++; $display("FAIL stuffed_data got=%h want=ff", wrQA[0]); end
      total++;
      if (eofQA[0] !== eof_t'({8'd1, 1'b0, 1'b0})) begin
        bad++; $display("FAIL stuffed_eof got=%h want=%h", eofQA[0], eof_t'({8'd1, 1'b0, 1'b0}));
      end
    end
  endtask

  task automatic test_abort;
    int tA;
    clear_log();
    send_raw(8'h7E);
    send_raw(8'h11);
    send_raw(8'hFE);
    tA = edgeCnt;
    idle(10);
    total++;
    if (wrQA.size() !== 1 || (wrQA.size() == 1 && wrQA[0] !== 8'h11)) begin
      bad++; $display("FAIL abort_data got=%0d bytes want=1 byte 11", wrQA.size());
    end
    total++;
    if (abDetQ.size() !== 1 || abSigQ.size() !== 1) begin
      bad++; $display("FAIL abort_counts got det=%0d sig=%0d want det=1 sig=1", abDetQ.size(), abSigQ.size());
    end else begin
      total++;
      if (abDetQ[0] !== tA + 2) begin bad++; $display("FAIL abort_det_edge got=%0d want=%0d", abDetQ[0], tA + 2); end
      total++;
      if (abSigQ[0] !== abDetQ[0] + 1) begin bad++; $display("FAIL abort_sig_edge got=%0d want=%0d", abSigQ[0], abDetQ[0] + 1); end
      total++;
      if (abSigVf !== 1'b0) begin bad++; $display("FAIL abort_valid_low got=%b want=0", abSigVf); end
    end
    total++;
    if (eofQA.size() !== 0 || vfA !== 1'b0) begin
      bad++; $display("FAIL abort_no_eof got eof=%0d vf=%b want eof=0 vf=0", eofQA.size(), vfA);
    end
  endtask

  task automatic test_frame_error;
    int tO, tC;
    clear_log();
    txBytes = '{8'h5A};
    send_frame(3, 8'b0000_0101, tO, tC);
    idle(10);
    total++;
    if (wrQA.size() !== 1 || eofQA.size() !== 1) begin
      bad++; $display("FAIL ferr_counts got wr=%0d eof=%0d want wr=1 eof=1", wrQA.size(), eofQA.size());
    end else begin
      total++;
      if (wrQA[0] !== 8'h5A) begin bad++; $display("FAIL ferr_data got=%h want=5a", wrQA[0]); end
      total++;
      if (eofQA[0] !== eof_t'({8'd1, 1'b1, 1'b0})) begin
        bad++; $display("FAIL ferr_eof got=%h want=%h", eofQA[0], eof_t'({8'd1, 1'b1, 1'b0}));
      end
    end
  endtask

  task automatic test_overflow;
    int tO, tC;
    logic [7:0] sent[$];
    clear_log();
    txBytes.delete();
    for (int i = 0; i < 6; i++) txBytes.push_back(8'($urandom));
    sent = txBytes;
    send_frame(0, 8'h00, tO, tC);
    idle(10);
    total++;
    if (wrQA.size() !== 6 || wrQB.size() !== 4) begin
      bad++; $display("FAIL ovf_wr_counts got A=%0d B=%0d want A=6 B=4", wrQA.size(), wrQB.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wrQB[i] !== sent[i]) begin bad++; $display("FAIL ovf_wr_data[%0d] got=%h want=%h", i, wrQB[i], sent[i]); end
      end
    end
    total++;
    if (eofQB.size() !== 1 || (eofQB.size() == 1 && eofQB[0] !== eof_t'({8'd4, 1'b0, 1'b1}))) begin
      bad++; $display("FAIL ovf_eof got n=%0d want one eof size=4 ovf=1", eofQB.size());
    end
    total++;
    if (ovB !== 1'b1 || ovA !== 1'b0) begin bad++; $display("FAIL ovf_hold got B=%b A=%b want B=1 A=0", ovB, ovA); end
    txBytes = '{8'h42};
    send_frame(0, 8'h00, tO, tC);
    idle(10);
    total++;
    if (ovB !== 1'b0 || eofQB.size() !== 2 || (eofQB.size() == 2 && eofQB[1] !== eof_t'({8'd1, 1'b0, 1'b0}))) begin
      bad++; $display("FAIL ovf_clear got ovf=%b neof=%0d want ovf=0 neof=2", ovB, eofQB.size());
    end
  endtask

  task automatic test_back_to_back;
    clear_log();
    send_raw(8'h7E);
    for (int i = 0; i < 7; i++) send_bit(i < 6);
    idle(10);
    total++;
    if (flagQ.size() !== 2 || wrQA.size() !== 0 || eofQA.size() !== 0 || abSigQ.size() !== 0) begin
      bad++; $display("FAIL b2b got flags=%0d wr=%0d eof=%0d asig=%0d want 2,0,0,0",
                      flagQ.size(), wrQA.size(), eofQA.size(), abSigQ.size());
    end
  endtask

  task automatic test_random;
    int tO, tC, n, np;
    logic [7:0] pb;
    logic [7:0] expA[$], expB[$];
    eof_t eA[$], eB[$];
    clear_log();
    for (int f = 0; f < 10; f++) begin
      n  = $urandom_range(0, 6);
      np = $urandom_range(0, 7);
      pb = 8'($urandom);
      txBytes.delete();
      for (int i = 0; i < n; i++) begin
        txBytes.push_back(8'($urandom));
        expA.push_back(txBytes[i]);
        if (i < 4) expB.push_back(txBytes[i]);
      end
      if (n * 8 + np > 0) begin
        eA.push_back({8'(n), np != 0, 1'b0});
        eB.push_back({8'(n > 4 ? 4 : n), np != 0, n > 4});
      end
      send_frame(np, pb, tO, tC);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(8, 12));
    end
    idle(12);
    total++;
    if (wrQA.size() !== expA.size() || wrQB.size() !== expB.size()) begin
      bad++; $display("FAIL rand_wr_counts got A=%0d B=%0d want A=%0d B=%0d", wrQA.size(), wrQB.size(), expA.size(), expB.size());
    end else begin
      foreach (expA[i]) begin
        total++;
        if (wrQA[i] !== expA[i]) begin bad++; $display("FAIL rand_wrA[%0d] got=%h want=%h", i, wrQA[i], expA[i]); end
      end
      foreach (expB[i]) begin
        total++;
        if (wrQB[i] !== expB[i]) begin bad++; $display("FAIL rand_wrB[%0d] got=%h want=%h", i, wrQB[i], expB[i]); end
      end
    end
    total++;
    if (eofQA.size() !== eA.size() || eofQB.size() !== eB.size()) begin
      bad++; $display("FAIL rand_eof_counts got A=%0d B=%0d want %0d", eofQA.size(), eofQB.size(), eA.size());
    end else begin
      foreach (eA[i]) begin
        total++;
        if (eofQA[i] !== eA[i] || eofQB[i] !== eB[i]) begin
          bad++; $display("FAIL rand_eof[%0d] got A=%h B=%h want A=%h B=%h", i, eofQA[i], eofQB[i], eA[i], eB[i]);
        end
      end
    end
    total++;
    if (abSigQ.size() !== 0) begin bad++; $display("FAIL rand_no_abortsig got=%0d want=0", abSigQ.size()); end
  endtask

  task automatic test_reset_mid;
    int tO, tC;
    clear_log();
    send_raw(8'h7E);
    send_raw(8'h33);
    send_raw(8'h0F);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2 Rst = 1'b1;
    #1;
    total++;
    if ({fdA, adA, vfA, asA, dA, wbA, eofA, feA, ovA, fsA} !== 30'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h want=0", {fdA, adA, vfA, asA, dA, wbA, eofA, feA, ovA, fsA});
    end
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0;
    idle(12);
    total++;
    if (wrQA.size() !== 1 || eofQA.size() !== 0 || abSigQ.size() !== 0) begin
      bad++; $display("FAIL rstmid_events got wr=%0d eof=%0d asig=%0d want 1,0,0", wrQA.size(), eofQA.size(), abSigQ.size());
    end
    clear_log();
    txBytes = '{8'hC3};
    send_frame(0, 8'h00, tO, tC);
    idle(10);
    total++;
    if (wrQA.size() !== 1 || (wrQA.size() == 1 && wrQA[0] !== 8'hC3) || eofQA.size() !== 1) begin
      bad++; $display("FAIL rstmid_recover got wr=%0d eof=%0d want 1,1", wrQA.size(), eofQA.size());
    end
  endtask

  task automatic test_disable_mid;
    int tO, tC;
    clear_log();
    send_raw(8'h7E);
    send_raw(8'h96);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    RxEN = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    total++;
    if (vfA !== 1'b0 || ovA !== 1'b0 || ovB !== 1'b0) begin
      bad++; $display("FAIL dis_levels got vf=%b ovA=%b ovB=%b want 0,0,0", vfA, ovA, ovB);
    end
    RxEN = 1'b1;
    idle(12);
    total++;
    if (flagQ.size() !== 1 || wrQA.size() !== 0 || eofQA.size() !== 0 || abSigQ.size() !== 0) begin
      bad++; $display("FAIL dis_events got flags=%0d wr=%0d eof=%0d asig=%0d want 1,0,0,0",
                      flagQ.size(), wrQA.size(), eofQA.size(), abSigQ.size());
    end
    clear_log();
    txBytes = '{8'h5A, 8'hA5};
    send_frame(0, 8'h00, tO, tC);
    idle(10);
    total++;
    if (wrQA.size() !== 2 || eofQA.size() !== 1 || (eofQA.size() == 1 && eofQA[0] !== eof_t'({8'd2, 1'b0, 1'b0}))) begin
      bad++; $display("FAIL dis_recover got wr=%0d eof=%0d want 2,1", wrQA.size(), eofQA.size());
    end
  endtask

  initial begin
    Rst = 1'b1; RxEN = 1'b0; Rx = 1'b1;
    test_reset();
    test_basic();
    test_stuffed();
    test_abort();
    test_frame_error();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_disable_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
